// File: rtl/nbit_serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = A - B - bin, one bit per clock, LSB first.
// A single full-subtractor cell works on the low bits of the operand shift
// registers, and the borrow is held in a register between bits.
//
// Handshake: start is sampled only in IDLE. busy is high for exactly N cycles
// while bits are processed. done is a one-cycle pulse, and diff/bout/ovf are
// valid from that cycle until the next completion. start is ignored while busy
// or done is high.
module nbit_serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  r_sr;
  logic          br;
  logic [CW-1:0] cnt;

  logic d;
  logic br_next;

  // Full-subtractor cell on the current bit.
  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);

  // Control FSM and datapath. Results are committed only on the final bit,
  // so diff/bout/ovf stay stable throughout SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr <= {d, r_sr[N-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            // br here is the borrow into the MSB, br_next the borrow out of it.
            diff  <= {d, r_sr[N-1:1]};
            bout  <= br_next;
            ovf   <= br ^ br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// Testbench for nbit_serial_subtractor (N=4).
// Handshake under test: start is accepted on a rising edge only when the DUT
// is idle. busy is high for N cycles, then done pulses for one cycle with
// diff/bout/ovf valid.
module tb_nbit_serial_subtractor;

  localparam int N = 4;
  localparam int W = N + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int tests;
  int fails;
  int accepted;
  int done_seen;

  // Expected {ovf, bout, diff}, pushed at issue, popped by the monitor.
  logic [W-1:0] exp_q[$];

  nbit_serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Unsigned difference gives diff and borrow; signed range check gives ovf.
  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic bi);
    int ux, uy, sx, sy, ures, sres;
    logic [N-1:0] dd;
    logic bo, ov;
    ux   = int'(x);
    uy   = int'(y);
    sx   = (x[N-1]) ? ux - (1 << N) : ux;
    sy   = (y[N-1]) ? uy - (1 << N) : uy;
    ures = ux - uy - int'(bi);
    sres = sx - sy - int'(bi);
    dd   = N'((ures + (1 << N)) % (1 << N));
    bo   = (ures < 0);
    ov   = (sres < -(1 << (N - 1))) || (sres > (1 << (N - 1)) - 1);
    return {ov, bo, dd};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done pulse with no pending operation");
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        tests++;
        if ({ovf, bout, diff} !== e) begin
          fails++;
          $display("FAIL result: got ovf=%0b bout=%0b diff=%0h, expected ovf=%0b bout=%0b diff=%0h",
                   ovf, bout, diff, e[N+1], e[N], e[N-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one operation from IDLE and check the busy/done timing. With noise
  // set, start/A/B/bin are scrambled after the accepting edge.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                        input bit noise);
    int bad;
    @(negedge clk);
    a     = x;
    b     = y;
    bin   = bi;
    start = 1'b1;
    exp_q.push_back(model(x, y, bi));
    accepted++;
    @(posedge clk);
    bad = 0;
    for (int m = 0; m <= N; m++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        a   = N'($urandom_range(0, (1 << N) - 1));
        b   = N'($urandom_range(0, (1 << N) - 1));
        bin = 1'($urandom_range(0, 1));
      end
      if (m < N) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
      end else begin
        if (busy !== 1'b0 || done !== 1'b1) bad++;
      end
    end
    check("latency", 32'(bad), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dcount;
    logic [N:0] dpos;
    tests = 0; fails = 0; accepted = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, busy, done, diff, bout, ovf} , 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(4'd9, 4'd3, 1'b0, 1'b0);
    run_op(4'd3, 4'd9, 1'b0, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 1'b0);
    run_op(4'h7, 4'h8, 1'b0, 1'b0);
    run_op(4'h8, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_after_done", {25'd0, ovf, bout, diff}, {25'd0, 1'b1, 1'b0, 4'h7});

    // start held high; operands changed right after the first acceptance
    @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(4'd5, 4'd2, 1'b0));
    exp_q.push_back(model(4'd1, 4'd1, 1'b0));
    accepted += 2;
    @(posedge clk);
    #1;
    a = 4'd1; b = 4'd1;
    dcount = 0;
    dpos = '0;
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      if (m == 11) start = 1'b0;
      if (done) begin
        dcount++;
        if (m == 4) dpos[0] = 1'b1;
        if (m == 10) dpos[1] = 1'b1;
      end
      if (m == 4) check("held_first_diff", 32'(diff), 32'd3);
    end
    check("held_done_count", 32'(dcount), 32'd2);
    check("held_done_pos", 32'(dpos), 32'd3);

    // Reset in the second SHIFT cycle: outputs clear immediately, no done
    @(negedge clk);
    a = 4'd2; b = 4'd7; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, busy, done, diff, bout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_done_after_reset", 32'(dcount), 32'd0);
    run_op(4'd2, 4'd7, 1'b1, 1'b0);

    // Exhaustive sweep in a random order, with noise on the inputs while busy
    begin
      int order[$];
      for (int i = 0; i < (1 << (2 * N + 1)); i++) order.push_back(i);
      order.shuffle();
      foreach (order[i]) begin
        logic [2*N:0] v;
        v = (2 * N + 1)'(order[i]);
        run_op(v[N-1:0], v[2*N-1:N], v[2*N], 1'b1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    check("done_per_start", 32'(done_seen), 32'(accepted));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
